regfile_read_scoreboard: RTL and testbench

- Integer register file plus hazard scoreboard for the decode/issue stage.
- Architectural writes arrive from writeback. Decode reads two sources with same-cycle writeback bypass.
- Each destination register carries a pending bit. It is set at issue and cleared at writeback.
- Issue stalls on any RAW or WAW hazard against a still-pending register.

---
 rtl/regfile_read_scoreboard.sv | 139 +++++++++++++
 tb/tb_regfile_read_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_scoreboard
// Description : Integer register file with two bypassed read ports and a
//               per-register pending scoreboard that stalls decode/issue on
//               RAW and WAW hazards against outstanding producers.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              issue_valid,
    input  logic              issue_uses_rs1,
    input  logic              issue_uses_rs2,
    input  logic              issue_has_rd,
    input  logic [AW-1:0]     issue_rd,
    output logic              stall,
    output logic              issue_fire,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [AW:0]       pending_cnt
);

    localparam logic [AW-1:0] c_x0 = '0;

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [AW:0]      r_pending_cnt;

    logic [NREGS-1:0] w_wb_dec;
    logic [NREGS-1:0] w_set_dec;
    logic [NREGS-1:0] w_eff_pend;
    logic [NREGS-1:0] w_pend_next;
    logic [AW:0]      w_cnt_next;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_stall;
    logic             w_set_en;

    // A new producer is recorded only for an instruction that actually issues
    // and targets a real (non-x0) register.
    assign w_set_en = issue_fire & issue_has_rd & (issue_rd != c_x0);

    // Per-register decode of writeback and issue destination; x0 never
    // carries pending state.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend_bit
            assign w_wb_dec[gi]  = wb_en    && (wb_addr  == AW'(gi));
            assign w_set_dec[gi] = w_set_en && (issue_rd == AW'(gi));
            if (gi == 0) begin : g_x0
                assign w_eff_pend[gi]  = 1'b0;
                assign w_pend_next[gi] = 1'b0;
            end else begin : g_xn
                // A same-cycle writeback already resolves the hazard.
                assign w_eff_pend[gi]  = r_pending[gi] & ~w_wb_dec[gi];
                // Set dominates clear: the new producer is still outstanding.
                assign w_pend_next[gi] = w_eff_pend[gi] | w_set_dec[gi];
            end
        end
    endgenerate

    // Population count of the next-state pending vector.
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_pend_next[i]};
        end
    end

    // Source reads: x0 is zero, then write-first bypass, then the array.
    always_comb begin
        w_rs1_data = '0;
        if (rs1_addr != c_x0) begin
            if (wb_en && (wb_addr == rs1_addr)) begin
                w_rs1_data = wb_data;
            end else begin
                w_rs1_data = r_regs[rs1_addr];
            end
        end
    end

    // Second source read port, same priority as the first.
    always_comb begin
        w_rs2_data = '0;
        if (rs2_addr != c_x0) begin
            if (wb_en && (wb_addr == rs2_addr)) begin
                w_rs2_data = wb_data;
            end else begin
                w_rs2_data = r_regs[rs2_addr];
            end
        end
    end

    // Hazard check: RAW on either used source, WAW on the destination.
    always_comb begin
        w_stall = issue_valid & ((issue_uses_rs1 & w_eff_pend[rs1_addr]) |
                                 (issue_uses_rs2 & w_eff_pend[rs2_addr]) |
                                 (issue_has_rd   & w_eff_pend[issue_rd]));
    end

    assign rs1_data    = w_rs1_data;
    assign rs2_data    = w_rs2_data;
    assign stall       = w_stall;
    assign issue_fire  = issue_valid & ~w_stall;
    assign pending_cnt = r_pending_cnt;

    // Architectural register array; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != c_x0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard bits and their registered count advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pend_next;
            r_pending_cnt <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_read_scoreboard
// Description : Self-checking bench: directed vector table for the scoreboard
//               corner cases plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr, issue_rd, wb_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
    logic            issue_valid, issue_uses_rs1, issue_uses_rs2, issue_has_rd;
    logic            stall, issue_fire, wb_en;
    logic [AW:0]     pending_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_read_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_uses_rs1(issue_uses_rs1),
        .issue_uses_rs2(issue_uses_rs2), .issue_has_rd(issue_has_rd),
        .issue_rd(issue_rd), .stall(stall), .issue_fire(issue_fire),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending_cnt(pending_cnt)
    );

    typedef struct {
        logic            rst;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic            iv;
        logic            u1;
        logic            u2;
        logic            hrd;
        logic [AW-1:0]   rd;
        logic            wen;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] e_rs1;
        logic [XLEN-1:0] e_rs2;
        logic            e_stall;
        logic            e_fire;
        logic [AW:0]     e_cnt;
    } vec_t;

    // Reference model state
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock: drive at negedge, check combinational outputs, then the
    // registered count just after the rising edge.
    task automatic run_cycle(input vec_t v, input string tag);
        @(negedge clk);
        reset          = v.rst;
        rs1_addr       = v.rs1;
        rs2_addr       = v.rs2;
        issue_valid    = v.iv;
        issue_uses_rs1 = v.u1;
        issue_uses_rs2 = v.u2;
        issue_has_rd   = v.hrd;
        issue_rd       = v.rd;
        wb_en          = v.wen;
        wb_addr        = v.wa;
        wb_data        = v.wd;
        #1;
        chk({tag, ".rs1_data"}, rs1_data, v.e_rs1);
        chk({tag, ".rs2_data"}, rs2_data, v.e_rs2);
        chk({tag, ".stall"}, {63'd0, stall}, {63'd0, v.e_stall});
        chk({tag, ".issue_fire"}, {63'd0, issue_fire}, {63'd0, v.e_fire});
        @(posedge clk);
        #1;
        chk({tag, ".pending_cnt"}, {58'd0, pending_cnt}, {58'd0, v.e_cnt});
    endtask

    function automatic bit m_eff(input logic [AW-1:0] i, input vec_t v);
        return (i != 0) && m_pend[i] && !(v.wen && v.wa == i);
    endfunction

    // Fill in expected fields from the model, then advance the model.
    task automatic model_step(inout vec_t v);
        int cnt;
        v.e_rs1 = (v.rs1 == 0) ? '0 : (v.wen && v.wa == v.rs1) ? v.wd : m_regs[v.rs1];
        v.e_rs2 = (v.rs2 == 0) ? '0 : (v.wen && v.wa == v.rs2) ? v.wd : m_regs[v.rs2];
        v.e_stall = v.iv && ((v.u1 && m_eff(v.rs1, v)) || (v.u2 && m_eff(v.rs2, v)) ||
                             (v.hrd && m_eff(v.rd, v)));
        v.e_fire = v.iv && !v.e_stall;
        if (v.rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
        end else begin
            if (v.wen && v.wa != 0) m_regs[v.wa] = v.wd;
            if (v.wen) m_pend[v.wa] = 0;
            if (v.e_fire && v.hrd && v.rd != 0) m_pend[v.rd] = 1;
        end
        cnt = 0;
        for (int i = 0; i < NREGS; i++) cnt += int'(m_pend[i]);
        v.e_cnt = (AW+1)'(cnt);
    endtask

    vec_t tbl [24];
    vec_t v;

    initial begin
        //          rst rs1 rs2 iv u1 u2 hrd rd wen wa wd                       e_rs1                    e_rs2                  st fi cnt
        tbl[0]  = '{0, 0,  31, 0, 0, 0, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 0, 0};
        tbl[1]  = '{0, 0,  0,  0, 0, 0, 0,  0, 1,  0, 64'hFFFF,                64'h0,                   64'h0,                 0, 0, 0};
        tbl[2]  = '{0, 0,  0,  0, 0, 0, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 0, 0};
        tbl[3]  = '{0, 5,  1,  0, 0, 0, 0,  0, 1,  5, 64'hDEADBEEF01234567,    64'hDEADBEEF01234567,    64'h0,                 0, 0, 0};
        tbl[4]  = '{0, 5,  6,  0, 0, 0, 0,  0, 1,  6, 64'h11,                  64'hDEADBEEF01234567,    64'h11,                0, 0, 0};
        tbl[5]  = '{0, 6,  5,  0, 0, 0, 0,  0, 0,  0, 64'h0,                   64'h11,                  64'hDEADBEEF01234567,  0, 0, 0};
        tbl[6]  = '{0, 0,  0,  1, 0, 0, 1,  7, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 1};
        tbl[7]  = '{0, 7,  0,  1, 1, 0, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 1, 0, 1};
        tbl[8]  = '{0, 7,  0,  1, 1, 0, 0,  0, 1,  7, 64'h42,                  64'h42,                  64'h0,                 0, 1, 0};
        tbl[9]  = '{0, 7,  0,  0, 0, 0, 0,  0, 0,  0, 64'h0,                   64'h42,                  64'h0,                 0, 0, 0};
        tbl[10] = '{0, 0,  0,  1, 0, 0, 1,  9, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 1};
        tbl[11] = '{0, 0,  0,  1, 0, 0, 1,  9, 0,  0, 64'h0,                   64'h0,                   64'h0,                 1, 0, 1};
        tbl[12] = '{0, 0,  0,  1, 0, 0, 1,  9, 1,  9, 64'h99,                  64'h0,                   64'h0,                 0, 1, 1};
        tbl[13] = '{0, 9,  0,  1, 1, 0, 0,  0, 0,  0, 64'h0,                   64'h99,                  64'h0,                 1, 0, 1};
        tbl[14] = '{0, 9,  0,  0, 0, 0, 0,  0, 1,  9, 64'h77,                  64'h77,                  64'h0,                 0, 0, 0};
        tbl[15] = '{0, 0,  0,  1, 0, 0, 1,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 0};
        tbl[16] = '{0, 0,  0,  1, 1, 1, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 0};
        tbl[17] = '{0, 0,  0,  1, 0, 0, 1,  1, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 1};
        tbl[18] = '{0, 0,  0,  1, 0, 0, 1,  2, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 2};
        tbl[19] = '{0, 0,  0,  1, 0, 0, 1,  3, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 3};
        tbl[20] = '{0, 1,  0,  0, 1, 0, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 0, 3};
        tbl[21] = '{0, 0,  2,  1, 0, 1, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 1, 0, 3};
        tbl[22] = '{1, 4,  5,  0, 0, 0, 0,  0, 1,  4, 64'hABC,                 64'hABC,                 64'hDEADBEEF01234567,  0, 0, 0};
        tbl[23] = '{0, 4,  5,  1, 1, 0, 0,  0, 0,  0, 64'h0,                   64'h0,                   64'h0,                 0, 1, 0};

        reset = 1'b1;
        {rs1_addr, rs2_addr, issue_rd, wb_addr} = '0;
        {issue_valid, issue_uses_rs1, issue_uses_rs2, issue_has_rd, wb_en} = '0;
        wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.pending_cnt", {58'd0, pending_cnt}, 64'd0);

        // Every register reads zero after reset; no hazards exist.
        for (int i = 0; i < NREGS; i++) begin
            v = '{0, AW'(i), AW'(NREGS-1-i), 1, 1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 1, 0};
            run_cycle(v, $sformatf("readall[%0d]", i));
        end

        for (int k = 0; k < 24; k++) begin
            run_cycle(tbl[k], $sformatf("vec[%0d]", k));
        end

        // Randomized traffic against the reference model, starting clean.
        v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 0};
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        run_cycle(v, "rnd_reset");
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            v.rst = ($urandom_range(0, 79) == 0);
            v.rs1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            v.rs2 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            v.rd  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            v.wa  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            v.iv  = ($urandom_range(0, 3) != 0);
            v.u1  = 1'($urandom);
            v.u2  = 1'($urandom);
            v.hrd = 1'($urandom);
            v.wen = ($urandom_range(0, 2) == 0);
            v.wd  = {$urandom, $urandom};
            model_step(v);
            run_cycle(v, $sformatf("rnd[%0d]", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
